lfsr_rand_arb: RTL

- Controller that owns one Fibonacci LFSR and shares its pseudo-random output between NUM_REQ requesters.
- Arbitration is round-robin. Each winner gets one fresh value, taken after STEPS LFSR advances.
- Also handles seed configuration and run gating.
- Sits between the LFSR datapath and any random-number consumers; software loads the seed through the cfg port.

---
 rtl/lfsr_rand_arb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lfsr_rand_arb.sv
// lfsr_rand_arb: a single Fibonacci LFSR shared round-robin between NUM_REQ
// requesters. Each round picks a winner, advances the LFSR STEPS times and
// hands the winner the freshly generated value with a one-cycle grant.
// Software can load a seed through the cfg port while the block is idle.
//
// Optional build macro: LFSR_LOCKUP_RECOVER_EN
//   defined   - an all-zero cfg seed loads DEFAULT_SEED instead and sets the
//               sticky lockup_o flag (cleared only by reset).
//   undefined - an all-zero seed is loaded as-is; lockup_o stays 0.
`timescale 1ns/1ps

module lfsr_rand_arb #(
    parameter int                 WIDTH        = 4,
    parameter logic [WIDTH-1:0]   TAPS         = 4'b1001,
    parameter int                 NUM_REQ      = 3,
    parameter int                 STEPS        = 1,
    parameter logic [WIDTH-1:0]   DEFAULT_SEED = 4'b0001
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic               cfg_load_i,
    input  logic [WIDTH-1:0]   cfg_seed_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               rnd_valid_o,
    output logic [WIDTH-1:0]   rnd_o,
    output logic [WIDTH-1:0]   lfsr_o,
    output logic               busy_o,
    output logic               lockup_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STEP  = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [PW-1:0]    ptr;        // requester with highest priority
    logic [PW-1:0]    win;        // winner of the round in progress
    logic [3:0]       cnt;        // advances still to make this round
    logic             lockup_q;

    logic [PW-1:0]    cand;
    logic [PW-1:0]    pick;
    logic             pick_found;

    assign lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    assign lfsr_o    = lfsr;
    assign lockup_o  = lockup_q;

    // Round-robin search: first asserted request at or after ptr, cyclic.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path can
        // leave it unassigned, which would otherwise infer a latch.
        cand       = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PW'((int'(ptr) + i) % NUM_REQ);
            if (!pick_found && req_i[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Arbitration FSM, LFSR datapath and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            lfsr        <= DEFAULT_SEED;
            ptr         <= '0;
            win         <= '0;
            cnt         <= '0;
            lockup_q    <= 1'b0;
            gnt_o       <= '0;
            rnd_valid_o <= 1'b0;
            rnd_o       <= '0;
            busy_o      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register here samples pre-edge values regardless of order.
            gnt_o       <= '0;
            rnd_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_load_i) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
                        if (cfg_seed_i == '0) begin
                            lfsr     <= DEFAULT_SEED;
                            lockup_q <= 1'b1;
                        end else begin
                            lfsr <= cfg_seed_i;
                        end
`else
                        lfsr <= cfg_seed_i;
`endif
                    end else if (en_i && pick_found) begin
                        win    <= pick;
                        cnt    <= 4'(STEPS);
                        state  <= S_STEP;
                        busy_o <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (!req_i[win]) begin
                        // Winner withdrew: abandon, keep advances already made.
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        lfsr <= lfsr_next;
                        if (cnt == 4'd1) begin
                            state       <= S_GRANT;
                            gnt_o       <= NUM_REQ'(1) << win;
                            rnd_valid_o <= 1'b1;
                            rnd_o       <= lfsr_next;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                S_GRANT: begin
                    ptr    <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
